// File: rtl/tri_root_fsm.sv
// Triangular-root finder: subtracts 1, 2, 3, ... from a latched operand, one
// step per clock, and reports the largest n with n(n+1)/2 <= value.
module tri_root_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [4:0] root,
    output logic [4:0] rem,
    output logic       exact
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q,   state_d;
    logic [7:0] residue_q, residue_d;
    logic [4:0] k_q,       k_d;
    logic [4:0] n_work_q,  n_work_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;
    logic [4:0] root_q,    root_d;
    logic [4:0] rem_q,     rem_d;
    logic       exact_q,   exact_d;

    always_comb begin
        // NOTE: every next-state signal defaults to its register first, so no
        // path through the case statement can leave one unassigned (no latch).
        state_d   = state_q;
        residue_d = residue_q;
        k_d       = k_q;
        n_work_d  = n_work_q;
        busy_d    = busy_q;
        done_d    = done_q;
        root_d    = root_q;
        rem_d     = rem_q;
        exact_d   = exact_q;

        if (abort) begin
            // Cancel wins over start and sequencing; the last result is kept.
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        residue_d = value;
                        k_d       = 5'd1;
                        n_work_d  = 5'd0;
                        busy_d    = 1'b1;
                        state_d   = SUB;
                    end
                end
                SUB: begin
                    // The compare guards the subtract, so the residue never wraps.
                    if (residue_q >= {3'b000, k_q}) begin
                        residue_d = residue_q - {3'b000, k_q};
                        n_work_d  = k_q;
                        k_d       = k_q + 5'd1;
                    end else begin
                        root_d  = n_work_q;
                        rem_d   = residue_q[4:0];
                        exact_d = (residue_q == 8'd0);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            residue_q <= 8'd0;
            k_q       <= 5'd0;
            n_work_q  <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            root_q    <= 5'd0;
            rem_q     <= 5'd0;
            exact_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            k_q       <= k_d;
            n_work_q  <= n_work_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            root_q    <= root_d;
            rem_q     <= rem_d;
            exact_q   <= exact_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign root  = root_q;
    assign rem   = rem_q;
    assign exact = exact_q;

endmodule
